// File: rtl/sd_blk_pkg.sv
// Shared types and constants for the sd_lba/sd_rd/sd_wr/sd_ack block responder.
package sd_blk_pkg;

  localparam int BLK_BYTES = 512;
  localparam int BLK_SHIFT = 9;
  localparam int ACK_GAP   = 2;

  typedef enum logic [2:0] {
    IDLE,
    RD_REQ,
    RD_WAIT,
    RD_PUSH,
    WR_ADDR,
    WR_LAT,
    WR_MEM,
    DONE
  } state_t;

  // A request is serviced without touching memory when no image is present
  // or the block lies beyond the end of the image.
  function automatic logic out_of_range(input logic        mounted,
                                        input logic [31:0] lba,
                                        input logic [31:0] blocks);
    return !mounted || (lba >= blocks);
  endfunction

endpackage

// File: rtl/sd_block_responder.sv
// Services one 512-byte block per sd_rd/sd_wr request against a byte-wide
// backing image memory. Reads push bytes into the initiator's buffer, writes
// pull bytes from it. Out-of-range requests still run the full handshake but
// never touch memory.
module sd_block_responder
  import sd_blk_pkg::*;
#(
  parameter int ADDR_W  = 24,
  parameter int DIN_LAT = 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [31:0]       sd_lba,
  input  logic              sd_rd,
  input  logic              sd_wr,
  output logic              sd_ack,
  output logic [8:0]        sd_buff_addr,
  output logic [7:0]        sd_buff_dout,
  output logic              sd_buff_wr,
  input  logic [7:0]        sd_buff_din,
  input  logic              img_mounted,
  input  logic [31:0]       img_blocks,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_rd,
  output logic              mem_wr,
  output logic [7:0]        mem_wdata,
  input  logic [7:0]        mem_rdata,
  input  logic              mem_ready
);

  localparam int LAT_W = (DIN_LAT > 1) ? $clog2(DIN_LAT) : 1;

  state_t             state, state_next;
  logic [9:0]         cnt;        // bit 9 set once the whole block is done
  logic [ADDR_W-1:0]  base;
  logic               oor;
  logic [7:0]         rdata_q;
  logic [7:0]         wdata_q;
  logic [LAT_W-1:0]   lat_cnt;
  logic [1:0]         gap_cnt;

  logic accept, cnt_inc, cap_rd, cap_wr;
  logic last, lat_done, gap_done;

  assign last     = (cnt == 10'(BLK_BYTES - 1));
  assign lat_done = (int'(lat_cnt) == DIN_LAT - 1);
  assign gap_done = (int'(gap_cnt) == ACK_GAP - 1);

  assign sd_buff_addr = cnt[BLK_SHIFT-1:0];
  assign sd_buff_dout = rdata_q;
  assign mem_wdata    = wdata_q;
  assign mem_addr     = base + ADDR_W'(cnt[BLK_SHIFT-1:0]);

  // State register.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples the pre-edge values, independent of block evaluation order.
    if (reset) state <= IDLE;
    else       state <= state_next;
  end

  // Next-state logic and Moore-style handshake outputs.
  always_comb begin
    // NOTE: every signal gets a default before the case so no path can
    // leave one unassigned and infer a latch.
    state_next = state;
    accept     = 1'b0;
    cnt_inc    = 1'b0;
    cap_rd     = 1'b0;
    cap_wr     = 1'b0;
    sd_ack     = 1'b0;
    sd_buff_wr = 1'b0;
    mem_rd     = 1'b0;
    mem_wr     = 1'b0;

    case (state)
      IDLE: begin
        // Read wins when both requests are raised together.
        if (sd_rd) begin
          accept     = 1'b1;
          state_next = RD_REQ;
        end else if (sd_wr) begin
          accept     = 1'b1;
          state_next = WR_ADDR;
        end
      end

      RD_REQ: begin
        sd_ack     = 1'b1;
        mem_rd     = !oor;
        state_next = RD_WAIT;
      end

      RD_WAIT: begin
        sd_ack = 1'b1;
        mem_rd = !oor;
        if (oor || mem_ready) begin
          cap_rd     = 1'b1;
          state_next = RD_PUSH;
        end
      end

      RD_PUSH: begin
        sd_ack     = 1'b1;
        sd_buff_wr = 1'b1;
        cnt_inc    = 1'b1;
        state_next = last ? DONE : RD_REQ;
      end

      WR_ADDR: begin
        sd_ack = 1'b1;
        // A zero-latency buffer port has din valid alongside the address.
        if (DIN_LAT == 0) begin
          cap_wr     = 1'b1;
          state_next = WR_MEM;
        end else begin
          state_next = WR_LAT;
        end
      end

      WR_LAT: begin
        sd_ack = 1'b1;
        if (lat_done) begin
          cap_wr     = 1'b1;
          state_next = WR_MEM;
        end
      end

      WR_MEM: begin
        sd_ack = 1'b1;
        mem_wr = !oor;
        if (oor || mem_ready) begin
          cnt_inc    = 1'b1;
          state_next = last ? DONE : WR_ADDR;
        end
      end

      DONE: begin
        // ack stays low here so the initiator always sees the falling edge.
        if (gap_done) state_next = IDLE;
      end

      default: state_next = IDLE;
    endcase
  end

  // Request latch, byte counter, data capture and latency/gap timers.
  always_ff @(posedge clk) begin
    if (reset) begin
      cnt     <= '0;
      base    <= '0;
      oor     <= 1'b0;
      rdata_q <= '0;
      wdata_q <= '0;
      lat_cnt <= '0;
      gap_cnt <= '0;
    end else begin
      if (accept) begin
        cnt  <= '0;
        base <= ADDR_W'({sd_lba, BLK_SHIFT'(0)});
        oor  <= out_of_range(img_mounted, sd_lba, img_blocks);
      end else if (cnt_inc) begin
        cnt <= cnt + 10'd1;
      end

      if (cap_rd) rdata_q <= oor ? 8'h00 : mem_rdata;
      if (cap_wr) wdata_q <= sd_buff_din;

      lat_cnt <= (state == WR_LAT) ? lat_cnt + LAT_W'(1) : '0;
      gap_cnt <= (state == DONE)   ? gap_cnt + 2'd1      : '0;
    end
  end

endmodule

// File: tb/tb_sd_block_responder.sv
// Self-checking bench for sd_block_responder: randomized-latency image
// memory, registered initiator buffer, and a byte-array reference image.
module tb_sd_block_responder;

  localparam int BLK = 512;

  logic        clk;
  logic        reset;
  logic [31:0] sd_lba;
  logic        sd_rd, sd_wr;
  logic        sd_ack;
  logic [8:0]  sd_buff_addr;
  logic [7:0]  sd_buff_dout;
  logic        sd_buff_wr;
  logic [7:0]  sd_buff_din;
  logic        img_mounted;
  logic [31:0] img_blocks;
  logic [23:0] mem_addr;
  logic        mem_rd, mem_wr;
  logic [7:0]  mem_wdata;
  logic [7:0]  mem_rdata;
  logic        mem_ready;

  sd_block_responder #(.ADDR_W(24), .DIN_LAT(1)) dut (
    .clk          (clk),
    .reset        (reset),
    .sd_lba       (sd_lba),
    .sd_rd        (sd_rd),
    .sd_wr        (sd_wr),
    .sd_ack       (sd_ack),
    .sd_buff_addr (sd_buff_addr),
    .sd_buff_dout (sd_buff_dout),
    .sd_buff_wr   (sd_buff_wr),
    .sd_buff_din  (sd_buff_din),
    .img_mounted  (img_mounted),
    .img_blocks   (img_blocks),
    .mem_addr     (mem_addr),
    .mem_rd       (mem_rd),
    .mem_wr       (mem_wr),
    .mem_wdata    (mem_wdata),
    .mem_rdata    (mem_rdata),
    .mem_ready    (mem_ready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Image memory (sd_img_mem) and the bench's own view of what it should hold.
  logic [7:0] img     [0:65535];
  logic [7:0] ref_img [0:65535];
  int         wait_left;

  // Memory model: random 0-5 cycle latency, one-cycle mem_ready pulse.
  always @(posedge clk) begin
    int lat;
    if (reset) begin
      mem_ready <= 1'b0;
      wait_left <= -1;
    end else if (mem_ready) begin
      mem_ready <= 1'b0;
    end else if (mem_rd || mem_wr) begin
      lat = (wait_left < 0) ? int'($urandom_range(0, 5)) : wait_left;
      if (lat == 0) begin
        mem_ready <= 1'b1;
        wait_left <= -1;
        if (mem_rd) mem_rdata <= img[mem_addr[15:0]];
        if (mem_wr) img[mem_addr[15:0]] <= mem_wdata;
      end else begin
        wait_left <= lat - 1;
      end
    end
  end

  // Initiator buffer read port with one registered cycle of latency.
  logic [7:0] wbuf [0:BLK-1];
  always @(posedge clk) sd_buff_din <= wbuf[sd_buff_addr];

  // Initiator-side monitor, sampled on the falling edge.
  logic [7:0] rbuf [0:BLK-1];
  int pushes = 0, order_bad = 0, memrd_cnt = 0, memwr_cnt = 0, ack_rises = 0, exp_addr = 0;
  logic ack_prev = 1'b0;
  always @(negedge clk) begin
    if (sd_ack && !ack_prev) begin
      ack_rises++;
      exp_addr = 0;
    end
    if (sd_buff_wr) begin
      if (int'(sd_buff_addr) != exp_addr) order_bad++;
      rbuf[sd_buff_addr] = sd_buff_dout;
      exp_addr++;
      pushes++;
    end
    if (mem_rd) memrd_cnt++;
    if (mem_wr) memwr_cnt++;
    ack_prev = sd_ack;
  end

  function automatic bit in_range(input logic [31:0] lba);
    return img_mounted && (lba < img_blocks);
  endfunction

  function automatic int mem_diff();
    int n = 0;
    for (int k = 0; k < 65536; k++) if (img[k] !== ref_img[k]) n++;
    return n;
  endfunction

  task automatic wait_ack(input logic level, input int budget, input string tag);
    int n = 0;
    while (sd_ack !== level && n < budget) begin
      @(negedge clk);
      n++;
    end
    check({tag, "_ack"}, 64'(sd_ack), 64'(level));
  endtask

  task automatic start_req(input bit rd, input bit wr, input logic [31:0] lba, input string tag);
    @(negedge clk);
    sd_lba = lba;
    sd_rd  = rd;
    sd_wr  = wr;
    wait_ack(1'b1, 20, {tag, "_rise"});
  endtask

  // Initiator drops its request once ack is seen; ack must fall once and stay low.
  task automatic finish_req(input string tag);
    int hi = 0;
    sd_rd  = 1'b0;
    sd_wr  = 1'b0;
    sd_lba = $urandom;
    wait_ack(1'b0, 12000, {tag, "_fall"});
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      if (sd_ack) hi++;
    end
    check({tag, "_quiet"}, 64'(hi), 64'd0);
  endtask

  task automatic do_read(input logic [31:0] lba, input string tag);
    logic [7:0] exp_b [0:BLK-1];
    int p0 = pushes, o0 = order_bad, r0 = memrd_cnt, mis = 0;
    bit ok = in_range(lba);
    for (int i = 0; i < BLK; i++) exp_b[i] = ok ? ref_img[lba * BLK + i] : 8'h00;
    start_req(1'b1, 1'b0, lba, tag);
    finish_req(tag);
    for (int i = 0; i < BLK; i++) if (rbuf[i] !== exp_b[i]) mis++;
    check({tag, "_pushes"}, 64'(pushes - p0), 64'(BLK));
    check({tag, "_order"}, 64'(order_bad - o0), 64'd0);
    check({tag, "_data"}, 64'(mis), 64'd0);
    if (!ok) check({tag, "_no_memrd"}, 64'(memrd_cnt - r0), 64'd0);
  endtask

  task automatic do_write(input logic [31:0] lba, input string tag);
    int p0 = pushes, w0 = memwr_cnt, a0 = ack_rises;
    bit ok = in_range(lba);
    start_req(1'b0, 1'b1, lba, tag);
    finish_req(tag);
    if (ok) for (int i = 0; i < BLK; i++) ref_img[lba * BLK + i] = wbuf[i];
    check({tag, "_no_push"}, 64'(pushes - p0), 64'd0);
    check({tag, "_one_ack"}, 64'(ack_rises - a0), 64'd1);
    if (!ok) check({tag, "_no_memwr"}, 64'(memwr_cnt - w0), 64'd0);
    check({tag, "_mem"}, 64'(mem_diff()), 64'd0);
  endtask

  logic [7:0] track [0:13*BLK-1];

  initial begin
    int mis, p0, gap;
    logic [7:0] blk5 [0:BLK-1];

    for (int k = 0; k < 65536; k++) begin
      img[k]     = 8'(k) ^ 8'h5A;
      ref_img[k] = 8'(k) ^ 8'h5A;
    end
    for (int i = 0; i < BLK; i++) wbuf[i] = 8'h00;
    reset       = 1'b1;
    sd_lba      = '0;
    sd_rd       = 1'b0;
    sd_wr       = 1'b0;
    img_mounted = 1'b1;
    img_blocks  = 32'd100;
    repeat (3) @(negedge clk);

    check("rst_ack",   64'(sd_ack), 64'd0);
    check("rst_bwr",   64'(sd_buff_wr), 64'd0);
    check("rst_memrd", 64'(mem_rd), 64'd0);
    check("rst_memwr", 64'(mem_wr), 64'd0);
    check("rst_addr",  64'(sd_buff_addr), 64'd0);
    check("rst_dout",  64'(sd_buff_dout), 64'd0);
    check("rst_maddr", 64'(mem_addr), 64'd0);
    reset = 1'b0;

    // Plain read of block 3, with a spot check straight from the image formula.
    do_read(32'd3, "rd3");
    check("rd3_byte7", 64'(rbuf[7]), 64'(8'(1536 + 7) ^ 8'h5A));

    // Write block 7 with ~i from the initiator buffer.
    for (int i = 0; i < BLK; i++) wbuf[i] = ~8'(i);
    do_write(32'd7, "wr7");
    mis = 0;
    for (int i = 0; i < BLK; i++) if (img[3584 + i] !== ~8'(i)) mis++;
    check("wr7_bytes", 64'(mis), 64'd0);

    // Out-of-range read (lba == img_blocks) and write with no image.
    do_read(32'd100, "rd_oor");
    img_mounted = 1'b0;
    for (int i = 0; i < BLK; i++) wbuf[i] = 8'($urandom);
    do_write(32'd4, "wr_unmounted");
    img_mounted = 1'b1;

    // Track load: 13 chained reads of blocks 26..38.
    for (int b = 0; b < 13; b++) begin
      do_read(32'(26 + b), "trk");
      for (int i = 0; i < BLK; i++) track[b * BLK + i] = rbuf[i];
    end
    mis = 0;
    for (int j = 0; j < 13 * BLK; j++) if (track[j] !== ref_img[13312 + j]) mis++;
    check("track2", 64'(mis), 64'd0);

    // Read and write raised together: read first, held write after the gap.
    for (int i = 0; i < BLK; i++) begin
      wbuf[i] = 8'($urandom);
      blk5[i] = ref_img[5 * BLK + i];
    end
    p0 = pushes;
    start_req(1'b1, 1'b1, 32'd5, "both");
    sd_rd = 1'b0;
    wait_ack(1'b0, 12000, "both_rd_fall");
    check("both_rd_pushes", 64'(pushes - p0), 64'(BLK));
    mis = 0;
    for (int i = 0; i < BLK; i++) if (rbuf[i] !== blk5[i]) mis++;
    check("both_rd_data", 64'(mis), 64'd0);
    gap = 0;
    while (!sd_ack && gap < 20) begin
      @(negedge clk);
      gap++;
    end
    check("both_gap_ge2", 64'(gap >= 2), 64'd1);
    check("both_wr_ack", 64'(sd_ack), 64'd1);
    p0 = pushes;
    finish_req("both_wr");
    for (int i = 0; i < BLK; i++) ref_img[5 * BLK + i] = wbuf[i];
    check("both_wr_no_push", 64'(pushes - p0), 64'd0);
    check("both_wr_mem", 64'(mem_diff()), 64'd0);

    // Reset while the write of block 10 is at byte 200.
    for (int i = 0; i < BLK; i++) wbuf[i] = ~8'(i);
    start_req(1'b0, 1'b1, 32'd10, "rstwr");
    sd_wr = 1'b0;
    mis = 0;
    while (!(sd_ack && sd_buff_addr == 9'd200) && mis < 6000) begin
      @(negedge clk);
      mis++;
    end
    check("rstwr_reached200", 64'(sd_buff_addr), 64'd200);
    reset = 1'b1;
    @(negedge clk);
    check("rstwr_ack", 64'(sd_ack), 64'd0);
    check("rstwr_memwr", 64'(mem_wr), 64'd0);
    check("rstwr_bwr", 64'(sd_buff_wr), 64'd0);
    reset = 1'b0;
    for (int i = 0; i < 200; i++) ref_img[10 * BLK + i] = wbuf[i];
    do_read(32'd0, "rd0_after_rst");

    // Randomized requests against the reference image.
    for (int t = 0; t < 4; t++) begin
      logic [31:0] lba = 32'($urandom_range(0, 110));
      img_mounted = ($urandom_range(0, 3) != 0);
      if ($urandom_range(0, 1) == 1) begin
        do_read(lba, "rnd_rd");
      end else begin
        for (int i = 0; i < BLK; i++) wbuf[i] = 8'($urandom);
        do_write(lba, "rnd_wr");
      end
    end
    img_mounted = 1'b1;

    check("final_mem", 64'(mem_diff()), 64'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/sd_block_responder.md
Name: sd_block_responder

Overview:
- Simulation and FPGA-side responder for the sd_lba/sd_rd/sd_wr/sd_ack block protocol used by floppy_track and similar track-buffer initiators.
- It services one 512-byte block per request against a byte-wide backing image memory, such as the SDRAM or BRAM that holds a .dsk/.po image.
- Reads stream bytes into the initiator's buffer via sd_buff_addr/sd_buff_dout/sd_buff_wr.
- Writes fetch bytes from the initiator via sd_buff_din.

Parameters:
- ADDR_W, 24, byte-address width of the backing memory port. Image byte address = {lba, 9'b0} truncated to ADDR_W.
- DIN_LAT, 1, cycles from sd_buff_addr change to valid sd_buff_din, matching the initiator's registered buffer read port.

Ports:
- clk  in  1  system clock
- reset  in  1  synchronous, active-high
- sd_lba  in  32  block number, sampled at request accept
- sd_rd  in  1  read request, level, held by initiator until sd_ack seen
- sd_wr  in  1  write request, same rules as sd_rd
- sd_ack  out  1  high for the whole transfer; falling edge marks completion
- sd_buff_addr  out  9  byte index within block
- sd_buff_dout  out  8  read data to initiator
- sd_buff_wr  out  1  one-cycle strobe, read data valid
- sd_buff_din  in  8  write data from initiator
- img_mounted  in  1  image present
- img_blocks  in  32  image size in blocks
- mem_addr  out  ADDR_W  backing-memory byte address
- mem_rd  out  1  read strobe, held until mem_ready
- mem_wr  out  1  write strobe, held until mem_ready
- mem_wdata  out  8  write data
- mem_rdata  in  8  read data, valid when mem_ready
- mem_ready  in  1  completes the current mem_rd/mem_wr

Behaviour:
- Reset values: all outputs 0; state IDLE; byte counter 0.
- IDLE:
  - If sd_rd is high, latch sd_lba and raise sd_ack on the next cycle. sd_rd has priority when sd_rd and sd_wr are both high.
  - Otherwise, if sd_wr is high, do the same and enter the write path.
  - A request still pending when the transfer ends is accepted on the next IDLE pass.
- Out-of-range: a request is out of range when ~img_mounted or lba >= img_blocks (unsigned compare).
  - Full 512-byte handshake is still performed.
  - Read data is 8'h00; writes are discarded.
  - mem_rd/mem_wr are never asserted.
- Read path, cnt = 0..511, states RD_REQ -> RD_WAIT -> RD_PUSH:
  - RD_REQ: mem_addr = base + cnt, assert mem_rd.
  - RD_WAIT: hold mem_rd until mem_ready, then capture mem_rdata.
  - RD_PUSH: sd_buff_addr = cnt, sd_buff_dout = captured byte, sd_buff_wr = 1 for exactly one cycle.
  - After the push at cnt = 511, go to DONE; otherwise increment cnt and return to RD_REQ.
  - Zero-latency memory gives a minimum of 3 cycles per byte.
- Write path, states WR_ADDR -> WR_LAT (DIN_LAT cycles) -> WR_MEM:
  - WR_ADDR: drive sd_buff_addr = cnt.
  - WR_LAT: after DIN_LAT + 1 cycles, sample sd_buff_din into mem_wdata.
  - WR_MEM: assert mem_wr at base + cnt until mem_ready.
  - sd_buff_wr stays 0 throughout the write path.
- DONE:
  - Deassert sd_ack and hold it low for at least 2 cycles before returning to IDLE.
  - This guarantees the initiator sees the falling edge and can re-raise sd_rd/sd_wr without being double-serviced.
- sd_buff_addr wraps only via the transition to DONE and never exceeds 511. Counter is 10 bits internally; bit 9 = block complete.
- sd_rd/sd_wr dropping mid-transfer (initiator clears them once ack is seen) is normal and ignored.
- Changes to sd_lba, img_blocks or img_mounted after accept have no effect on the current transfer.
- Reset mid-transfer: return to IDLE on the next edge.
  - sd_ack, mem_rd, mem_wr and sd_buff_wr all go to 0.
  - A partial memory write is acceptable; the byte in flight is dropped.
- mem_ready while mem_rd/mem_wr is low is ignored.

Decomposition:
- Shared package sd_blk_pkg:
  - state enum (IDLE, RD_REQ, RD_WAIT, RD_PUSH, WR_ADDR, WR_LAT, WR_MEM, DONE)
  - BLK_BYTES = 512, BLK_SHIFT = 9, ACK_GAP = 2
- Single flat module; no sub-module is warranted.
- Bench memory model sd_img_mem (random mem_ready latency 0-5) lives in the testbench only.

Test Plan:
- Image byte k = k[7:0] ^ 8'h5A, img_blocks = 100; pulse sd_rd with sd_lba = 3 -> 512 sd_buff_wr strobes, addr 0..511 in order, dout = (1536 + addr)[7:0] ^ 8'h5A, then ack falls and stays low ≥ 2 cycles.
- sd_wr with lba = 7; initiator buffer byte i = ~i[7:0] via 1-cycle registered port -> memory bytes 3584..4095 equal ~i, no sd_buff_wr pulses, ack falls once.
- sd_rd with lba = 100, img_blocks = 100 -> 512 strobes of 8'h00, mem_rd never high; sd_wr with img_mounted = 0 -> mem_wr never high, memory unchanged.
- Drive an unmodified floppy_track loading track 2 (13 chained reads, lba 26..38) -> busy clears, track buffer matches image bytes 13312..19967.
- sd_rd and sd_wr both high at lba 5 -> read serviced first; wr still held is serviced after the ACK_GAP.
- Assert reset at byte 200 of a write -> next cycle sd_ack = 0, mem_wr = 0; a new sd_rd at lba 0 completes normally with correct data.
